// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_timer.sv
// ============================================================================
// Module      : seg_scan_timer
// Description : Up counter that restarts at zero after reaching last_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    assign tc_o = (count_q == last_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (tc_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : 4-digit common-anode 7-segment scan controller with blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank_en,
    output logic [3:0]  digit_out,
    output logic [3:0]  an,
    output logic        dp,
    output logic        load_ack
);

    localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);

    scan_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dpreg_q, dpreg_d;
    logic [3:0]  digit_out_d;
    logic [3:0]  an_d;
    logic        dp_d;
    logic        suppress;
    logic        tc;
    logic [CNT_W-1:0] last;

    assign last = (state_q == BLANK) ? CNT_W'(BLANK_CYCLES - 1)
                                     : CNT_W'(REFRESH_DIV - 1);

    seg_scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .last_i (last),
        .tc_o   (tc)
    );

    // Outputs are derived from next-state values so they move with the FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        digits_d    = load ? digits_in : digits_q;
        dpreg_d     = load ? dp_in : dpreg_q;
        digit_out_d = digit_out;
        an_d        = AN_OFF;
        dp_d        = 1'b1;
        suppress    = 1'b0;

        if (tc) begin
            if (state_q == BLANK) begin
                state_d = SHOW;
            end else begin
                state_d = BLANK;
                idx_d   = idx_q + 2'd1;
            end
        end

        if (state_d == SHOW) begin
            digit_out_d = digits_d[idx_d*4 +: 4];
            suppress    = lz_blank_en && (idx_d != 2'd0) &&
                          ((digits_d >> (idx_d * 4)) == 16'd0);
            if (!suppress) begin
                an_d[idx_d] = 1'b0;
                dp_d        = ~dpreg_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BLANK;
            idx_q     <= 2'd0;
            digits_q  <= 16'd0;
            dpreg_q   <= 4'd0;
            digit_out <= 4'd0;
            an        <= AN_OFF;
            dp        <= 1'b1;
            load_ack  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            digits_q  <= digits_d;
            dpreg_q   <= dpreg_d;
            digit_out <= digit_out_d;
            an        <= an_d;
            dp        <= dp_d;
            load_ack  <= load;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed and randomized checks of seg_scan_driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int R = 4;
    localparam int B = 2;
    localparam int SLOT = R + B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic        dp;
    logic        load_ack;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: scan position is a pure function of edges since reset.
    int          m_n = 0;
    int          m_slot = 0;
    int          m_off = 0;
    logic [15:0] m_dig = 16'd0;
    logic [3:0]  m_dp = 4'd0;
    logic [3:0]  m_last = 4'd0;
    logic        m_ack = 1'b0;
    logic [3:0]  exp_an;
    logic        exp_dp;

    seg_scan_driver #(
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .digit_out   (digit_out),
        .an          (an),
        .dp          (dp),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] dpv, input logic lz);
        logic show;
        logic supp;
        reset       = r;
        load        = ld;
        digits_in   = d;
        dp_in       = dpv;
        lz_blank_en = lz;
        @(posedge clk);
        if (r) begin
            m_n    = 0;
            m_dig  = 16'd0;
            m_dp   = 4'd0;
            m_last = 4'd0;
            m_ack  = 1'b0;
        end else begin
            m_n = m_n + 1;
            if (ld) begin
                m_dig = d;
                m_dp  = dpv;
            end
            m_ack = ld;
        end
        m_slot = (m_n / SLOT) % 4;
        m_off  = m_n % SLOT;
        show   = (m_off >= B);
        supp   = lz && (m_slot != 0) && ((m_dig >> (m_slot * 4)) == 16'd0);
        if (show) m_last = m_dig[m_slot*4 +: 4];
        exp_an = (show && !supp) ? ~(4'b0001 << m_slot) : 4'hF;
        exp_dp = (show && !supp) ? ~m_dp[m_slot] : 1'b1;
        #1;
        vectors = vectors + 4;
        assert (an === exp_an) else begin
            miscompares++;
            $error("FAIL an n=%0d observed=%b expected=%b", m_n, an, exp_an);
        end
        assert (dp === exp_dp) else begin
            miscompares++;
            $error("FAIL dp n=%0d observed=%b expected=%b", m_n, dp, exp_dp);
        end
        assert (digit_out === m_last) else begin
            miscompares++;
            $error("FAIL digit_out n=%0d observed=%h expected=%h", m_n, digit_out, m_last);
        end
        assert (load_ack === m_ack) else begin
            miscompares++;
            $error("FAIL load_ack n=%0d observed=%b expected=%b", m_n, load_ack, m_ack);
        end
    endtask

    initial begin
        int guard;
        logic [15:0] mask;
        logic        lz_r;

        // Reset, then idle scan with all-zero digits.
        tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

        // Single load pulse, then two full scans.
        tick(1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0);
        for (int i = 0; i < 2 * 4 * SLOT; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

        // Leading-zero suppression.
        tick(1'b0, 1'b1, 16'h0045, 4'b1111, 1'b1);
        for (int i = 0; i < 4 * SLOT; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
        tick(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4 * SLOT; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);

        // Load during the 2nd cycle of idx2's SHOW window, then reset mid-window.
        tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h5678, 4'h0, 1'b0);
        guard = 0;
        while (!(m_slot == 2 && m_off == B) && guard < 100) begin
            tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
            guard++;
        end
        vectors++;
        assert (guard < 100) else begin
            miscompares++;
            $error("FAIL reach_idx2 observed=%0d expected=<100", guard);
        end
        tick(1'b0, 1'b1, 16'h9999, 4'h0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4 * SLOT; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

        // Randomized traffic.
        lz_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            if ($urandom_range(0, 19) == 0) lz_r = ~lz_r;
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
                 16'($urandom) & mask, 4'($urandom), lz_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
